mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between the multi-cycle core and a DMA/loader port.

---
 rtl/mem_port_arbiter_if.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_port_arbiter_if
//------------------------------------------------------------------------------
// Bundles the three buses that meet at the memory port arbiter:
//   - core port  : cpu_rd, cpu_wr, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ack,
//                  cpu_stall
//   - DMA port   : dma_req, dma_we, dma_addr, dma_wdata -> dma_rdata, dma_ack
//   - memory port: mem_addr, mem_wdata, mem_re, mem_we <- mem_rdata
// Modports:
//   slave  : the arbiter's view (requests and read data in, strobes/acks out)
//   master : the environment's view (core, DMA engine and memory together)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Core side
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;
  // DMA / loader side
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;
  // Memory side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
//------------------------------------------------------------------------------
// Shares one unified instruction/data memory between the multi-cycle core and
// a DMA/loader port. Every access takes a grant cycle (IDLE), an issue cycle
// (strobe to memory) and a response cycle (ack, read data valid). The core has
// priority; a saturating wait counter lets a starved DMA win after MAX_WAIT
// cycles of waiting.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - mem_port_arbiter_if.slave (core, DMA and memory buses)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int             WCW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_ISS = 3'd1,
    CPU_RSP = 3'd2,
    DMA_ISS = 3'd3,
    DMA_RSP = 3'd4
  } state_t;

  state_t         state_q;
  logic [WCW-1:0] wait_cnt_q;
  logic [WCW-1:0] wait_cnt_d;
  // The memory-side address/data registers double as the request latch: they
  // are loaded only at the grant edge, so later payload changes are ignored.
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;
  logic           we_q;        // latched direction, 1 = write
  logic           mem_re_q;
  logic           mem_we_q;
  logic           cpu_ack_q;
  logic           dma_ack_q;
  logic [DW-1:0]  cpu_rdata_q;
  logic [DW-1:0]  dma_rdata_q;

  logic           cpu_req_w;
  logic           dma_busy_w;
  logic           grant_dma_d;
  logic           grant_cpu_d;

  always_comb begin
    cpu_req_w   = bus.cpu_rd | bus.cpu_wr;
    dma_busy_w  = (state_q == DMA_ISS) || (state_q == DMA_RSP);
    // A starved DMA overrides core priority; otherwise DMA only gets idle slots.
    grant_dma_d = (state_q == IDLE) && bus.dma_req &&
                  ((wait_cnt_q == WAIT_MAX) || !cpu_req_w);
    grant_cpu_d = (state_q == IDLE) && !grant_dma_d && cpu_req_w;

    wait_cnt_d = wait_cnt_q;
    if (!bus.dma_req || grant_dma_d) begin
      wait_cnt_d = '0;
    end else if (!dma_busy_w && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      we_q        <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      // Strobes and acks are single-cycle pulses by default.
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_dma_d) begin
            state_q     <= DMA_ISS;
            mem_addr_q  <= bus.dma_addr;
            mem_wdata_q <= bus.dma_wdata;
            we_q        <= bus.dma_we;
            mem_re_q    <= ~bus.dma_we;
            mem_we_q    <= bus.dma_we;
          end else if (grant_cpu_d) begin
            // cpu_rd and cpu_wr together resolve to a write.
            state_q     <= CPU_ISS;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            we_q        <= bus.cpu_wr;
            mem_re_q    <= ~bus.cpu_wr;
            mem_we_q    <= bus.cpu_wr;
          end
        end
        CPU_ISS: begin
          state_q   <= CPU_RSP;
          cpu_ack_q <= 1'b1;
        end
        CPU_RSP: begin
          state_q <= IDLE;
          if (!we_q) cpu_rdata_q <= bus.mem_rdata;
        end
        DMA_ISS: begin
          state_q   <= DMA_RSP;
          dma_ack_q <= 1'b1;
        end
        DMA_RSP: begin
          state_q <= IDLE;
          if (!we_q) dma_rdata_q <= bus.mem_rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory read data arrives during the response cycle, so it is forwarded
  // straight through while ack is high and captured for holding afterwards.
  assign bus.cpu_rdata = ((state_q == CPU_RSP) && !we_q) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dma_rdata = ((state_q == DMA_RSP) && !we_q) ? bus.mem_rdata : dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_stall = cpu_req_w & ~cpu_ack_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter
//------------------------------------------------------------------------------
// Directed testbench for mem_port_arbiter. Drives core and DMA requests, models
// a synchronous word memory behind the memory port, and checks every ack
// against a per-port scoreboard of expected transactions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  txn_t cpu_sb[$];
  txn_t dma_sb[$];
  logic [31:0] mem_arr [0:255];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write on the strobe edge, read data one cycle later.
  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem_arr[bus.mem_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: writes are verified in the memory model, reads on rdata.
  always @(negedge clk) begin
    if (!rst && bus.cpu_ack) begin
      if (cpu_sb.size() == 0) check("cpu unexpected ack", 32'd1, 32'd0);
      else begin
        txn_t e;
        e = cpu_sb.pop_front();
        if (e.we) check("sb cpu write", mem_arr[e.addr[9:2]], e.data);
        else      check("sb cpu rdata", bus.cpu_rdata, e.data);
      end
    end
    if (!rst && bus.dma_ack) begin
      if (dma_sb.size() == 0) check("dma unexpected ack", 32'd1, 32'd0);
      else begin
        txn_t e;
        e = dma_sb.pop_front();
        if (e.we) check("sb dma write", mem_arr[e.addr[9:2]], e.data);
        else      check("sb dma rdata", bus.dma_rdata, e.data);
      end
    end
  end

  // Counts negedges until the selected ack; -1 when the bound expires.
  task automatic wait_ack(input bit is_dma, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_dma ? bus.dma_ack : bus.cpu_ack) && n < 40);
    if (!(is_dma ? bus.dma_ack : bus.cpu_ack)) n = -1;
  endtask

  initial begin
    int n;
    int cpu_acks;
    int dma_at;
    int strobes;
    txn_t rd20;

    checks = 0;
    errors = 0;
    rd20   = '{we: 1'b0, addr: 32'h20, data: 32'hDEADBEEF};
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[8] = 32'hDEADBEEF;   // byte address 0x20
    bus.mem_rdata = '0;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset while a core write is being issued
    bus.cpu_wr = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hAAAA5555;
    @(negedge clk);
    check("t1 mem_we in issue", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("t1 mem_we async drop", {31'd0, bus.mem_we}, 32'd0);
    bus.cpu_wr = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1 mem_re", {31'd0, bus.mem_re}, 32'd0);
    check("t1 mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("t1 acks", {30'd0, bus.cpu_ack, bus.dma_ack}, 32'd0);
    check("t1 cpu_rdata", bus.cpu_rdata, 32'd0);
    check("t1 dma_rdata", bus.dma_rdata, 32'd0);
    check("t1 mem_addr", bus.mem_addr, 32'd0);
    check("t1 no write landed", mem_arr[4], 32'd0);
    @(negedge clk);
    check("t1 no ack later", {30'd0, bus.cpu_ack, bus.dma_ack}, 32'd0);

    // 2: single core read
    bus.cpu_rd = 1; bus.cpu_addr = 32'h20;
    cpu_sb.push_back(rd20);
    #1;
    check("t2 stall c0", {31'd0, bus.cpu_stall}, 32'd1);
    @(negedge clk);
    check("t2 mem_re c1", {31'd0, bus.mem_re}, 32'd1);
    check("t2 mem_addr c1", bus.mem_addr, 32'h20);
    check("t2 stall c1", {31'd0, bus.cpu_stall}, 32'd1);
    @(negedge clk);
    check("t2 ack c2", {31'd0, bus.cpu_ack}, 32'd1);
    check("t2 rdata c2", bus.cpu_rdata, 32'hDEADBEEF);
    check("t2 stall c2", {31'd0, bus.cpu_stall}, 32'd0);
    bus.cpu_rd = 0;
    repeat (2) @(negedge clk);

    // 3: simultaneous core write and DMA read, counter at zero -> core first
    bus.cpu_wr = 1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'hCAFE0001;
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h20;
    cpu_sb.push_back('{we: 1'b1, addr: 32'h80, data: 32'hCAFE0001});
    dma_sb.push_back(rd20);
    wait_ack(1'b0, n);
    check("t3 cpu ack latency", n, 32'd2);
    check("t3 dma not first", {31'd0, bus.dma_ack}, 32'd0);
    bus.cpu_wr = 0;
    wait_ack(1'b1, n);
    check("t3 dma after cpu", n, 32'd3);
    bus.dma_req = 0;
    repeat (2) @(negedge clk);

    // 4: core requests back-to-back, DMA held. Counter reaches 8 in the fourth
    // IDLE slot (arbitrations at wait 0,3,6,8) -> DMA ack 11 cycles in.
    bus.cpu_rd = 1; bus.cpu_addr = 32'h20;
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h20;
    cpu_sb.push_back(rd20);
    dma_sb.push_back(rd20);
    cpu_acks = 0;
    dma_at   = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        cpu_acks++;
        cpu_sb.push_back(rd20);
      end
      if (bus.dma_ack) begin
        dma_at = i;
        break;
      end
    end
    check("t4 cpu accesses before dma", cpu_acks, 32'd3);
    check("t4 dma latency", dma_at, 32'd11);
    bus.dma_req = 0;
    wait_ack(1'b0, n);
    check("t4 cpu resumes", n, 32'd3);
    bus.cpu_rd = 0;
    repeat (2) @(negedge clk);

    // 5: DMA write then core read of the same word
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h40; bus.dma_wdata = 32'h12345678;
    dma_sb.push_back('{we: 1'b1, addr: 32'h40, data: 32'h12345678});
    @(negedge clk);
    check("t5 mem_we", {31'd0, bus.mem_we}, 32'd1);
    check("t5 mem_re", {31'd0, bus.mem_re}, 32'd0);
    check("t5 mem_addr", bus.mem_addr, 32'h40);
    check("t5 mem_wdata", bus.mem_wdata, 32'h12345678);
    wait_ack(1'b1, n);
    check("t5 dma ack", n, 32'd1);
    check("t5 dma_rdata held on write", bus.dma_rdata, 32'hDEADBEEF);
    bus.dma_req = 0;
    repeat (2) @(negedge clk);
    bus.cpu_rd = 1; bus.cpu_addr = 32'h40;
    cpu_sb.push_back('{we: 1'b0, addr: 32'h40, data: 32'h12345678});
    wait_ack(1'b0, n);
    check("t5 cpu ack", n, 32'd2);
    bus.cpu_rd = 0;
    @(negedge clk);
    check("t5 cpu_rdata held", bus.cpu_rdata, 32'h12345678);
    repeat (2) @(negedge clk);

    // 6: payload change after grant, DMA request withdrawn before grant
    bus.cpu_rd = 1; bus.cpu_addr = 32'h20;
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h50;
    cpu_sb.push_back(rd20);
    @(negedge clk);
    bus.cpu_addr = 32'h44;
    bus.dma_req  = 0;
    #1;
    check("t6 latched mem_addr", bus.mem_addr, 32'h20);
    wait_ack(1'b0, n);
    check("t6 cpu ack", n, 32'd1);
    bus.cpu_rd = 0;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_re || bus.mem_we || bus.dma_ack) strobes++;
    end
    check("t6 no dma access", strobes, 32'd0);

    check("end cpu sb empty", cpu_sb.size(), 32'd0);
    check("end dma sb empty", dma_sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
